// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding, flag indices and the single-cycle
// ALU evaluation used by alu_exec.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] result;
    logic [3:0] flags;
    logic       wb;
  } exec_res_t;

  function automatic exec_res_t alu_compute(input logic [3:0] op,
                                            input logic [3:0] a,
                                            input logic [3:0] b);
    exec_res_t  r;
    logic [4:0] wide;
    logic [1:0] sh;
    r    = '0;
    r.wb = 1'b1;
    wide = '0;
    sh   = b[1:0];
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r.result = wide[3:0];
        r.flags[FLAG_CARRY] = wide[4];
        r.flags[FLAG_OVF]   = (a[3] == b[3]) && (wide[3] != a[3]);
      end
      OP_SUB, OP_CMP: begin
        // Bit 4 of the widened difference is the borrow (A < B unsigned).
        wide = {1'b0, a} - {1'b0, b};
        r.result = wide[3:0];
        r.flags[FLAG_CARRY] = wide[4];
        r.flags[FLAG_OVF]   = (a[3] != b[3]) && (wide[3] != a[3]);
        r.wb = (op == OP_SUB);
      end
      OP_AND: r.result = a & b;
      OP_OR:  r.result = a | b;
      OP_XOR: r.result = a ^ b;
      OP_NOT: r.result = ~a;
      OP_SHL: begin
        r.result = a << sh;
        case (sh)
          2'd0:    r.flags[FLAG_CARRY] = 1'b0;
          2'd1:    r.flags[FLAG_CARRY] = a[3];
          2'd2:    r.flags[FLAG_CARRY] = a[2];
          default: r.flags[FLAG_CARRY] = a[1];
        endcase
      end
      OP_SHR: begin
        r.result = a >> sh;
        case (sh)
          2'd0:    r.flags[FLAG_CARRY] = 1'b0;
          2'd1:    r.flags[FLAG_CARRY] = a[0];
          2'd2:    r.flags[FLAG_CARRY] = a[1];
          default: r.flags[FLAG_CARRY] = a[2];
        endcase
      end
      OP_MUL: ; // product is produced by alu_mul_iter, never evaluated here
      default: begin
        r.result          = '0;
        r.flags[FLAG_ERR] = 1'b1;
        r.wb              = 1'b0;
      end
    endcase
    r.flags[FLAG_ZERO] = (r.result == 4'd0) && !r.flags[FLAG_ERR];
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative 4x4 unsigned shift-add multiplier: one multiplier bit per step,
// LSB first; product/done reflect the value after the step in progress.
module alu_mul_iter
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       done
);

  logic [7:0] acc_q, acc_d;
  logic [7:0] mcand_q, mcand_d;
  logic [3:0] mplier_q, mplier_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] partial;

  assign partial = mplier_q[0] ? mcand_q : 8'd0;
  assign product = acc_q + partial;
  assign done    = step && (cnt_q == 2'd3);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {4'd0, a};
      mplier_d = b;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU execute stage with registered results and register-file
// write-back strobe; MUL runs through the iterative multiplier.
module alu_exec
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] alu_op,
  input  logic [3:0] rd_reg1,
  input  logic [3:0] rd_reg2,
  input  logic       dest,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [3:0] result_hi,
  output logic [3:0] flags,
  output logic       wb_en,
  output logic       wb_addr,
  output logic [3:0] wb_data
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d, a_q, a_d, b_q, b_d;
  logic       dest_q, dest_d;
  logic       busy_q, busy_d, done_q, done_d, wb_en_q, wb_en_d, wb_addr_q, wb_addr_d;
  logic [3:0] result_q, result_d, result_hi_q, result_hi_d, flags_q, flags_d;
  logic       mul_load, mul_step, mul_done;
  logic [7:0] mul_product;
  exec_res_t  ex;

  assign ex = alu_compute(op_q, a_q, b_q);

  alu_mul_iter u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .step    (mul_step),
    .a       (rd_reg1),
    .b       (rd_reg2),
    .product (mul_product),
    .done    (mul_done)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    dest_d      = dest_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    wb_addr_d   = wb_addr_q;
    wb_en_d     = 1'b0;
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = alu_op;
          a_d    = rd_reg1;
          b_d    = rd_reg2;
          dest_d = dest;
          if (alu_op == OP_MUL) begin
            state_d  = ST_MUL;
            mul_load = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_d     = ST_DONE;
        result_d    = ex.result;
        result_hi_d = '0;
        flags_d     = ex.flags;
        wb_en_d     = ex.wb;
        wb_addr_d   = dest_q;
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_done) begin
          state_d                 = ST_DONE;
          {result_hi_d, result_d} = mul_product;
          flags_d                 = '0;
          flags_d[FLAG_CARRY]     = (mul_product[7:4] != 4'd0);
          flags_d[FLAG_ZERO]      = (mul_product == 8'd0);
          wb_en_d                 = 1'b1;
          wb_addr_d               = dest_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered copies of the state being entered.
    busy_d = (state_d == ST_EXEC) || (state_d == ST_MUL);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dest_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dest_q      <= dest_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = result_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, reset corner
// cases, and random operations against an arithmetic reference model.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] alu_op, rd_reg1, rd_reg2;
  logic       dest;
  logic       busy, done, wb_en, wb_addr;
  logic [3:0] result, result_hi, flags, wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] hi;
    logic [3:0] f;   // {err, ovf, carry, zero}
    logic       wb;
  } exp_t;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       d;
    exp_t       e;
  } vec_t;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_op    (alu_op),
    .rd_reg1   (rd_reg1),
    .rd_reg2   (rd_reg2),
    .dest      (dest),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int sa, sb, s, n, res, hi;
    bit carry, ovf, err, zero;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    n = b % 4;
    res = 0; hi = 0; carry = 0; ovf = 0; err = 0;
    e = '0;
    e.wb = 1'b1;
    case (op)
      0: begin s = a + b; res = s % 16; carry = (s > 15);
               ovf = (sa + sb > 7) || (sa + sb < -8); end
      1, 9: begin s = a - b; res = (s + 16) % 16; carry = (a < b);
                  ovf = (sa - sb > 7) || (sa - sb < -8);
                  if (op == 9) e.wb = 1'b0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 15 - a;
      6: begin s = a * (1 << n); res = s % 16; carry = (n != 0) && ((s / 16) % 2 == 1); end
      7: begin res = a / (1 << n); carry = (n != 0) && (((a / (1 << (n - 1))) % 2) == 1); end
      8: begin s = a * b; res = s % 16; hi = s / 16; carry = (hi != 0); end
      default: begin err = 1; e.wb = 1'b0; end
    endcase
    zero = (op == 8) ? (a * b == 0) : (!err && res == 0);
    e.r  = 4'(res);
    e.hi = 4'(hi);
    e.f  = {err, ovf, carry, zero};
    return e;
  endfunction

  // Caller is positioned at a negedge with the DUT idle. Returns at the
  // negedge of the IDLE cycle following DONE, so the next call tests
  // back-to-back acceptance.
  task automatic do_op(input logic [3:0] op, a, b, input logic d, input exp_t e,
                       input bit poke, input string tag);
    int lat;
    int exp_lat;
    exp_lat = (op == 4'd8) ? 5 : 2;
    start = 1'b1; alu_op = op; rd_reg1 = a; rd_reg2 = b; dest = d;
    @(negedge clk);
    start = 1'b0;
    rd_reg1 = 4'($urandom); rd_reg2 = 4'($urandom); alu_op = 4'($urandom); dest = ~d;
    lat = 1;
    check({tag, " busy_after_accept"}, busy, 1);
    while (!done && lat < 12) begin
      if (poke && lat == 2) begin start = 1'b1; alu_op = 4'd0; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_in_done"}, busy, 0);
    check({tag, " result"}, result, e.r);
    check({tag, " result_hi"}, result_hi, e.hi);
    check({tag, " flags"}, flags, e.f);
    check({tag, " wb_en"}, wb_en, e.wb);
    check({tag, " wb_addr"}, wb_addr, d);
    check({tag, " wb_data"}, wb_data, e.r);
    if (poke) begin start = 1'b1; alu_op = 4'd2; end
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_pulse"}, done, 0);
    check({tag, " wb_en_pulse"}, wb_en, 0);
    check({tag, " idle_not_busy"}, busy, 0);
    check({tag, " result_held"}, {result_hi, result, flags}, {e.hi, e.r, e.f});
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    int seen;
    exp_t e;
    logic [3:0] op, a, b;

    vecs = '{
      '{4'd0,  4'd7,  4'd1, 1'b1, '{4'd8,  4'd0, 4'b0100, 1'b1}},  // ADD signed ovf
      '{4'd1,  4'd3,  4'd5, 1'b0, '{4'd14, 4'd0, 4'b0010, 1'b1}},  // SUB borrow
      '{4'd9,  4'd4,  4'd4, 1'b1, '{4'd0,  4'd0, 4'b0001, 1'b0}},  // CMP equal
      '{4'd6,  4'd9,  4'd1, 1'b0, '{4'd2,  4'd0, 4'b0010, 1'b1}},  // SHL carry out
      '{4'd7,  4'd9,  4'd0, 1'b1, '{4'd9,  4'd0, 4'b0000, 1'b1}},  // SHR by 0
      '{4'd12, 4'd5,  4'd3, 1'b0, '{4'd0,  4'd0, 4'b1000, 1'b0}},  // illegal
      '{4'd8,  4'd15, 4'd15,1'b1, '{4'd1,  4'd14,4'b0010, 1'b1}},  // MUL max
      '{4'd2,  4'd12, 4'd10,1'b0, '{4'd8,  4'd0, 4'b0000, 1'b1}},
      '{4'd3,  4'd0,  4'd0, 1'b1, '{4'd0,  4'd0, 4'b0001, 1'b1}},
      '{4'd4,  4'd5,  4'd5, 1'b0, '{4'd0,  4'd0, 4'b0001, 1'b1}},
      '{4'd5,  4'd5,  4'd0, 1'b1, '{4'd10, 4'd0, 4'b0000, 1'b1}},
      '{4'd6,  4'd15, 4'd3, 1'b0, '{4'd8,  4'd0, 4'b0010, 1'b1}},
      '{4'd7,  4'd12, 4'd3, 1'b1, '{4'd1,  4'd0, 4'b0010, 1'b1}},
      '{4'd0,  4'd15, 4'd1, 1'b0, '{4'd0,  4'd0, 4'b0011, 1'b1}},
      '{4'd1,  4'd8,  4'd1, 1'b1, '{4'd7,  4'd0, 4'b0100, 1'b1}},
      '{4'd9,  4'd3,  4'd5, 1'b0, '{4'd14, 4'd0, 4'b0010, 1'b0}},
      '{4'd8,  4'd0,  4'd9, 1'b1, '{4'd0,  4'd0, 4'b0001, 1'b1}},
      '{4'd8,  4'd3,  4'd5, 1'b0, '{4'd15, 4'd0, 4'b0000, 1'b1}},
      '{4'd15, 4'd1,  4'd1, 1'b1, '{4'd0,  4'd0, 4'b1000, 1'b0}}
    };

    // Reset with start held high: nothing may be accepted or reported.
    rst = 1'b0; start = 1'b1; alu_op = 4'd0; rd_reg1 = 4'd2; rd_reg2 = 4'd3; dest = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst outputs", {result, result_hi, flags, wb_en, wb_addr, wb_data}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("first_edge_accept busy", busy, 1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin @(negedge clk); lat++; end
    check("first_edge_accept done", done, 1);
    check("first_edge_accept result", result, 4'd5);
    check("first_edge_accept wb_en", wb_en, 1);
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].e,
            (vecs[i].op == 4'd8), $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom);
      a  = 4'($urandom);
      b  = 4'($urandom);
      e  = model(op, a, b);
      do_op(op, a, b, 1'($urandom), e, 1'($urandom), $sformatf("rnd%0d op%0d", i, op));
    end

    // Reset during the second MUL cycle aborts the op and clears all outputs.
    do_op(4'd0, 4'd7, 4'd1, 1'b1, model(0, 7, 1), 1'b0, "pre_abort");
    start = 1'b1; alu_op = 4'd8; rd_reg1 = 4'd15; rd_reg2 = 4'd15; dest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort outputs", {result, result_hi, flags, wb_en, wb_addr, wb_data}, 0);
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (wb_en || done) seen++;
    end
    check("abort no_wb", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
